alu_share_arbiter: RTL and testbench

Shares the single combinational execute-stage ALU between two requesters: port 0, the EX-stage issue path, and port 1, the branch/compare helper. It arbitrates round-robin, drives the ALU operand and control bus, and captures each result into a one-deep per-port response register with valid/ready handshakes. It sits between the pipeline's operand-select muxes and the ALU, and sanitises shift amounts and illegal opcodes before they reach the ALU.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_share_arbiter_rr_arb2.sv | 28 ++
 rtl/alu_share_arbiter.sv | 162 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, operation codes, response-slot states and
// the opcode classification helpers used by the ALU share arbiter.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_ADD     = 4'd0;
    localparam logic [CTRL_W-1:0] ALU_SUB     = 4'd1;
    localparam logic [CTRL_W-1:0] ALU_AND     = 4'd2;
    localparam logic [CTRL_W-1:0] ALU_OR      = 4'd3;
    localparam logic [CTRL_W-1:0] ALU_XOR     = 4'd4;
    localparam logic [CTRL_W-1:0] ALU_NOR     = 4'd5;
    localparam logic [CTRL_W-1:0] ALU_SLT     = 4'd6;
    localparam logic [CTRL_W-1:0] ALU_SLL     = 4'd7;
    localparam logic [CTRL_W-1:0] ALU_SRL     = 4'd8;
    localparam logic [CTRL_W-1:0] ALU_SRA     = 4'd9;
    localparam logic [CTRL_W-1:0] ALU_NUM_OPS = 4'd10;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    function automatic logic is_shift(input logic [CTRL_W-1:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

    function automatic logic is_illegal(input logic [CTRL_W-1:0] ctrl);
        return ctrl >= ALU_NUM_OPS;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: on contention the port that did not win last
// time is granted; the priority register only moves on a real grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant
);

    logic r_prio_last;

    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = r_prio_last ? 2'b01 : 2'b10;
        end
    end

    // Reset to 1 so port 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio_last <= 1'b1;
        end else if (|o_grant) begin
            r_prio_last <= o_grant[1];
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the EX issue path (port 0) and the
// branch/compare helper (port 1), with a one-deep response slot per port.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              r0_req_valid,
    output logic              r0_req_ready,
    input  logic [CTRL_W-1:0] r0_req_ctrl,
    input  logic [DATA_W-1:0] r0_req_a,
    input  logic [DATA_W-1:0] r0_req_b,
    input  logic [TAG_W-1:0]  r0_req_tag,
    output logic              r0_rsp_valid,
    input  logic              r0_rsp_ready,
    output logic [DATA_W-1:0] r0_rsp_result,
    output logic              r0_rsp_zero,
    output logic              r0_rsp_illegal,
    output logic [TAG_W-1:0]  r0_rsp_tag,
    input  logic              r1_req_valid,
    output logic              r1_req_ready,
    input  logic [CTRL_W-1:0] r1_req_ctrl,
    input  logic [DATA_W-1:0] r1_req_a,
    input  logic [DATA_W-1:0] r1_req_b,
    input  logic [TAG_W-1:0]  r1_req_tag,
    output logic              r1_rsp_valid,
    input  logic              r1_rsp_ready,
    output logic [DATA_W-1:0] r1_rsp_result,
    output logic              r1_rsp_zero,
    output logic              r1_rsp_illegal,
    output logic [TAG_W-1:0]  r1_rsp_tag,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic [15:0]       grant_cnt
);

    // Handshake: a request transfers on any cycle where req_valid and
    // req_ready are both 1; a response transfers when rsp_valid and rsp_ready
    // are both 1. req_ready is combinational and never depends on req_ready.

    logic [1:0]        w_req_valid;
    logic [1:0]        w_rsp_ready;
    logic [1:0]        w_rsp_valid;
    logic [1:0]        w_elig;
    logic [1:0]        w_grant;
    logic [1:0]        w_illegal;
    logic [CTRL_W-1:0] w_ctrl [2];
    logic [DATA_W-1:0] w_a    [2];
    logic [DATA_W-1:0] w_b    [2];
    logic [TAG_W-1:0]  w_tag  [2];
    logic [CTRL_W-1:0] w_alu_ctrl;
    logic [DATA_W-1:0] w_alu_a;
    logic [DATA_W-1:0] w_alu_b;

    slot_state_t       r_state   [2];
    logic [DATA_W-1:0] r_result  [2];
    logic [1:0]        r_zero;
    logic [1:0]        r_illegal;
    logic [TAG_W-1:0]  r_tag     [2];
    logic [15:0]       r_grant_cnt;

    assign w_req_valid = {r1_req_valid, r0_req_valid};
    assign w_rsp_ready = {r1_rsp_ready, r0_rsp_ready};
    assign w_ctrl[0] = r0_req_ctrl;
    assign w_ctrl[1] = r1_req_ctrl;
    assign w_a[0]    = r0_req_a;
    assign w_a[1]    = r1_req_a;
    assign w_b[0]    = r0_req_b;
    assign w_b[1]    = r1_req_b;
    assign w_tag[0]  = r0_req_tag;
    assign w_tag[1]  = r1_req_tag;

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            w_rsp_valid[n] = (r_state[n] == SLOT_FULL);
            w_illegal[n]   = is_illegal(w_ctrl[n]);
            // rst_n gating keeps ready and the ALU bus quiet while reset is held.
            w_elig[n]      = rst_n & w_req_valid[n] & ~flush &
                             (~w_rsp_valid[n] | w_rsp_ready[n]);
        end
    end

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (w_elig),
        .o_grant (w_grant)
    );

    // Illegal codes run the ALU as an add of zeros; shifts see only A[4:0].
    always_comb begin
        w_alu_ctrl = '0;
        w_alu_a    = '0;
        w_alu_b    = '0;
        for (int n = 0; n < 2; n++) begin
            if (w_grant[n] && !w_illegal[n]) begin
                w_alu_ctrl = w_ctrl[n];
                w_alu_b    = w_b[n];
                w_alu_a    = is_shift(w_ctrl[n]) ? {{(DATA_W-5){1'b0}}, w_a[n][4:0]}
                                                 : w_a[n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 2; n++) begin
                r_state[n]   <= SLOT_EMPTY;
                r_result[n]  <= '0;
                r_zero[n]    <= 1'b0;
                r_illegal[n] <= 1'b0;
                r_tag[n]     <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (flush) begin
                    r_state[n] <= SLOT_EMPTY;
                end else if (w_grant[n]) begin
                    r_state[n]   <= SLOT_FULL;
                    r_result[n]  <= w_illegal[n] ? '0 : alu_result;
                    r_zero[n]    <= ~w_illegal[n] & alu_zero;
                    r_illegal[n] <= w_illegal[n];
                    r_tag[n]     <= w_tag[n];
                end else if (r_state[n] == SLOT_FULL && w_rsp_ready[n]) begin
                    r_state[n] <= SLOT_EMPTY;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_cnt <= '0;
        end else if (|w_grant && r_grant_cnt != 16'hFFFF) begin
            r_grant_cnt <= r_grant_cnt + 16'd1;
        end
    end

    assign r0_req_ready   = w_grant[0];
    assign r1_req_ready   = w_grant[1];
    assign r0_rsp_valid   = w_rsp_valid[0];
    assign r1_rsp_valid   = w_rsp_valid[1];
    assign r0_rsp_result  = r_result[0];
    assign r1_rsp_result  = r_result[1];
    assign r0_rsp_zero    = r_zero[0];
    assign r1_rsp_zero    = r_zero[1];
    assign r0_rsp_illegal = r_illegal[0];
    assign r1_rsp_illegal = r_illegal[1];
    assign r0_rsp_tag     = r_tag[0];
    assign r1_rsp_tag     = r_tag[1];
    assign alu_ctrl       = w_alu_ctrl;
    assign alu_a          = w_alu_a;
    assign alu_b          = w_alu_b;
    assign grant_cnt      = r_grant_cnt;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomized bench for alu_share_arbiter against a
// cycle-level reference of the arbitration and response-slot rules.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int TAG_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              r0_req_valid = 1'b0, r1_req_valid = 1'b0;
    logic              r0_req_ready, r1_req_ready;
    logic [CTRL_W-1:0] r0_req_ctrl = '0, r1_req_ctrl = '0;
    logic [DATA_W-1:0] r0_req_a = '0, r0_req_b = '0, r1_req_a = '0, r1_req_b = '0;
    logic [TAG_W-1:0]  r0_req_tag = '0, r1_req_tag = '0;
    logic              r0_rsp_valid, r1_rsp_valid;
    logic              r0_rsp_ready = 1'b0, r1_rsp_ready = 1'b0;
    logic [DATA_W-1:0] r0_rsp_result, r1_rsp_result;
    logic              r0_rsp_zero, r1_rsp_zero, r0_rsp_illegal, r1_rsp_illegal;
    logic [TAG_W-1:0]  r0_rsp_tag, r1_rsp_tag;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic              alu_zero;
    logic [15:0]       grant_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference state
    logic              m_valid [2];
    logic [DATA_W-1:0] m_result[2];
    logic              m_zero  [2];
    logic              m_ill   [2];
    logic [TAG_W-1:0]  m_tag   [2];
    int                m_plast;
    int                m_cnt;
    int                last_grant;

    always #5 clk = ~clk;

    alu_share_arbiter #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
        .r0_req_ctrl(r0_req_ctrl), .r0_req_a(r0_req_a), .r0_req_b(r0_req_b),
        .r0_req_tag(r0_req_tag), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
        .r0_rsp_result(r0_rsp_result), .r0_rsp_zero(r0_rsp_zero),
        .r0_rsp_illegal(r0_rsp_illegal), .r0_rsp_tag(r0_rsp_tag),
        .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
        .r1_req_ctrl(r1_req_ctrl), .r1_req_a(r1_req_a), .r1_req_b(r1_req_b),
        .r1_req_tag(r1_req_tag), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
        .r1_rsp_result(r1_rsp_result), .r1_rsp_zero(r1_rsp_zero),
        .r1_rsp_illegal(r1_rsp_illegal), .r1_rsp_tag(r1_rsp_tag),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero), .grant_cnt(grant_cnt)
    );

    // Plain ALU: shifts use the whole A value, so unsanitised amounts show up.
    function automatic logic [DATA_W-1:0] alu_fn(input logic [CTRL_W-1:0] c,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~(a | b);
            4'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:    return b << a;
            4'd8:    return b >> a;
            4'd9:    return $unsigned($signed(b) >>> a);
            default: return '0;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_ctrl, alu_a, alu_b);
    assign alu_zero   = (alu_result == '0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_valid[n] = 1'b0; m_result[n] = '0; m_zero[n] = 1'b0;
            m_ill[n] = 1'b0;   m_tag[n] = '0;
        end
        m_plast = 1;
        m_cnt   = 0;
    endtask

    task automatic check_regs();
        chk("r0_rsp_valid",   r0_rsp_valid,   m_valid[0]);
        chk("r1_rsp_valid",   r1_rsp_valid,   m_valid[1]);
        chk("r0_rsp_result",  r0_rsp_result,  m_result[0]);
        chk("r1_rsp_result",  r1_rsp_result,  m_result[1]);
        chk("r0_rsp_zero",    r0_rsp_zero,    m_zero[0]);
        chk("r1_rsp_zero",    r1_rsp_zero,    m_zero[1]);
        chk("r0_rsp_illegal", r0_rsp_illegal, m_ill[0]);
        chk("r1_rsp_illegal", r1_rsp_illegal, m_ill[1]);
        chk("r0_rsp_tag",     r0_rsp_tag,     m_tag[0]);
        chk("r1_rsp_tag",     r1_rsp_tag,     m_tag[1]);
        chk("grant_cnt",      grant_cnt,      m_cnt);
    endtask

    // One clock of the reference: decide grant from the rules, check the
    // combinational outputs, cross the edge, update slots and check them.
    task automatic cycle();
        logic [1:0]        v, rr, elig;
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] a, b, ea, res;
        logic [TAG_W-1:0]  t;
        logic              ill, fl;
        int                g;
        #1;
        v  = {r1_req_valid, r0_req_valid};
        rr = {r1_rsp_ready, r0_rsp_ready};
        fl = flush;
        for (int n = 0; n < 2; n++)
            elig[n] = v[n] && (!m_valid[n] || rr[n]) && !fl;
        g = -1;
        if (elig == 2'b11)  g = (m_plast == 1) ? 0 : 1;
        else if (elig[0])   g = 0;
        else if (elig[1])   g = 1;
        c = '0; a = '0; b = '0; t = '0;
        if (g == 0) begin c = r0_req_ctrl; a = r0_req_a; b = r0_req_b; t = r0_req_tag; end
        if (g == 1) begin c = r1_req_ctrl; a = r1_req_a; b = r1_req_b; t = r1_req_tag; end
        ill = (g >= 0) && (int'(c) >= 10);
        ea  = (int'(c) >= 7 && int'(c) <= 9) ? (a % 32) : a;
        chk("r0_req_ready", r0_req_ready, g == 0);
        chk("r1_req_ready", r1_req_ready, g == 1);
        chk("alu_ctrl", alu_ctrl, (g < 0 || ill) ? 32'd0 : 32'(c));
        chk("alu_a",    alu_a,    (g < 0 || ill) ? 32'd0 : ea);
        chk("alu_b",    alu_b,    (g < 0 || ill) ? 32'd0 : b);
        last_grant = g;
        @(posedge clk);
        #1;
        for (int n = 0; n < 2; n++) begin
            if (fl) begin
                m_valid[n] = 1'b0;
            end else if (g == n) begin
                res         = ill ? 32'd0 : alu_fn(c, ea, b);
                m_valid[n]  = 1'b1;
                m_result[n] = res;
                m_zero[n]   = !ill && (res == 0);
                m_ill[n]    = ill;
                m_tag[n]    = t;
            end else if (rr[n]) begin
                m_valid[n] = 1'b0;
            end
        end
        if (g >= 0) begin
            m_plast = g;
            if (m_cnt < 65535) m_cnt++;
        end
        check_regs();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DATA_W-1:0] held;
        model_reset();
        // Reset values
        #3;
        check_regs();
        chk("reset_req_ready", {r1_req_ready, r0_req_ready}, 0);
        chk("reset_alu_ctrl", alu_ctrl, 0);
        apply_reset();

        // Contention: grants alternate starting with port 0
        r0_req_valid = 1; r1_req_valid = 1; r0_rsp_ready = 1; r1_rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            r0_req_ctrl = CTRL_W'($urandom_range(0, 9)); r0_req_a = $urandom; r0_req_b = $urandom;
            r1_req_ctrl = CTRL_W'($urandom_range(0, 9)); r1_req_a = $urandom; r1_req_b = $urandom;
            r0_req_tag = TAG_W'(i); r1_req_tag = TAG_W'(i + 8);
            cycle();
            chk("contention_order", last_grant, i % 2);
        end
        chk("contention_cnt", grant_cnt, 4);

        // Single subtract request
        r1_req_valid = 0;
        r0_req_ctrl = ALU_SUB; r0_req_a = 5; r0_req_b = 5; r0_req_tag = 4'hA;
        cycle();
        chk("single_grant", last_grant, 0);
        chk("single_valid", r0_rsp_valid, 1);
        chk("single_result", r0_rsp_result, 0);
        chk("single_zero", r0_rsp_zero, 1);
        chk("single_tag", r0_rsp_tag, 4'hA);
        r0_req_valid = 0;
        cycle();

        // Backpressure on port 1
        r1_req_valid = 1; r1_req_ctrl = ALU_ADD; r1_req_a = 1; r1_req_b = 2; r1_req_tag = 3;
        r1_rsp_ready = 0;
        cycle();
        held = r1_rsp_result;
        chk("bp_fill", held, 3);
        r1_req_a = 100; r1_req_tag = 7;
        r0_req_valid = 1; r0_rsp_ready = 1;
        for (int i = 0; i < 3; i++) begin
            r0_req_ctrl = CTRL_W'($urandom_range(0, 9)); r0_req_a = $urandom; r0_req_b = $urandom;
            cycle();
            chk("bp_r0_granted", last_grant, 0);
            chk("bp_r1_held", r1_rsp_result, 3);
            chk("bp_r1_tag", r1_rsp_tag, 3);
        end
        r1_req_valid = 0; r1_rsp_ready = 1;

        // Shift sanitise
        r0_req_ctrl = ALU_SLL; r0_req_a = 32'h23; r0_req_b = 1; r0_req_tag = 5;
        #1;
        chk("shift_alu_a", alu_a, 3);
        cycle();
        chk("shift_result", r0_rsp_result, 8);

        // Illegal code
        r0_req_ctrl = 4'd12; r0_req_a = 32'h1234; r0_req_b = 32'h55; r0_req_tag = 9;
        cycle();
        chk("illegal_grant", last_grant, 0);
        chk("illegal_flag", r0_rsp_illegal, 1);
        chk("illegal_result", r0_rsp_result, 0);
        chk("illegal_zero", r0_rsp_zero, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r0_req_valid = 1'($urandom_range(0, 1)); r1_req_valid = 1'($urandom_range(0, 1));
            r0_rsp_ready = 1'($urandom_range(0, 1)); r1_rsp_ready = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 15) == 0);
            r0_req_ctrl = CTRL_W'($urandom_range(0, 15)); r1_req_ctrl = CTRL_W'($urandom_range(0, 15));
            r0_req_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            r1_req_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            r0_req_b = $urandom; r1_req_b = ($urandom_range(0, 3) == 0) ? r1_req_a : $urandom;
            r0_req_tag = TAG_W'($urandom); r1_req_tag = TAG_W'($urandom);
            cycle();
        end
        flush = 0;

        // Flush with both slots full and a concurrent request
        r0_req_valid = 1; r1_req_valid = 1; r0_rsp_ready = 0; r1_rsp_ready = 0;
        r0_req_ctrl = ALU_OR; r1_req_ctrl = ALU_XOR;
        cycle();
        cycle();
        chk("flush_pre_full", {r1_rsp_valid, r0_rsp_valid}, 2'b11);
        r1_req_valid = 0; r0_rsp_ready = 1; flush = 1;
        #1;
        chk("flush_no_ready", r0_req_ready, 0);
        cycle();
        chk("flush_cleared", {r1_rsp_valid, r0_rsp_valid}, 2'b00);
        flush = 0;
        cycle();

        // Asynchronous reset mid-request
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_regs();
        chk("arst_req_ready", r0_req_ready, 0);
        chk("arst_alu_a", alu_a, 0);
        chk("arst_alu_b", alu_b, 0);
        chk("arst_alu_ctrl", alu_ctrl, 0);
        @(negedge clk);
        rst_n = 1;
        r0_req_valid = 0;
        @(posedge clk);
        #1;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
